xpb_table_gen: RTL

XPB_TABLE_GEN -- requirements
Module: xpb_table_gen

---
 rtl/xpb_table_gen.sv | 127 ++++++++++++
 1 files changed

// File: rtl/xpb_table_gen.sv
// Generates the 32-entry table (k*B) mod N, k = 0..31, one entry per accepted write.
// Optional build macro XPB_GEN_CHECK_EN adds the base_err output and a B < N check at start.
module xpb_table_gen (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [1023:0] modulus,
    input  logic [1023:0] base,
    input  logic          wr_ready,
    output logic          wr_en,
    output logic [4:0]    wr_addr,
    output logic [1023:0] wr_data,
    output logic          busy,
    output logic          done
`ifdef XPB_GEN_CHECK_EN
    ,
    output logic          base_err
`endif
);

    localparam int unsigned W = 1024;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e         state_q, state_d;
    logic [4:0]     idx_q, idx_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   mod_q, mod_d;
    logic [W-1:0]   base_q, base_d;
    logic [W:0]     sum;
    logic           sum_ge;
    logic [W-1:0]   acc_step;
`ifdef XPB_GEN_CHECK_EN
    logic           err_q, err_d;
`endif

    // acc and B are both < N, so one conditional subtraction keeps acc < N.
    always_comb begin
        sum      = {1'b0, acc_q} + {1'b0, base_q};
        sum_ge   = (sum >= {1'b0, mod_q});
        acc_step = sum_ge ? W'(sum - {1'b0, mod_q}) : sum[W-1:0];
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        mod_d   = mod_q;
        base_d  = base_q;
`ifdef XPB_GEN_CHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mod_d   = modulus;
                    base_d  = base;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = StCalc;
`ifdef XPB_GEN_CHECK_EN
                    if (base >= modulus) begin
                        state_d = StDone;
                        err_d   = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                    end
`endif
                end
            end
            StCalc: begin
                if (wr_ready) begin
                    if (idx_q == 5'd31) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 5'd1;
                        acc_d = acc_step;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            acc_q   <= '0;
            mod_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            mod_q   <= mod_d;
            base_q  <= base_d;
        end
    end

`ifdef XPB_GEN_CHECK_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign base_err = err_q;
`endif

    // Outputs decode straight from registers; address/data read as zero outside CALC.
    always_comb begin
        wr_en   = (state_q == StCalc);
        wr_addr = wr_en ? idx_q : 5'd0;
        wr_data = wr_en ? acc_q : '0;
        busy    = (state_q == StCalc) || (state_q == StDone);
        done    = (state_q == StDone);
    end

endmodule
